// File: rtl/stream_demux_n_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer.
//   - default widths for the block parameters
//   - holding-stage state encoding (EMPTY / BUSY)
package stream_demux_n_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_OUT  = 4;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_CNT_W  = 8;

  // EMPTY: nothing held. BUSY: a beat is held and at least one channel still owes a handshake.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_e;

endpackage

// File: rtl/stream_demux_n.sv
// stream_demux_n: 1-to-N stream demultiplexer with a single registered holding stage.
// A beat is routed to channel in_sel, or to every channel when in_bcast=1. Each
// channel has its own valid/ready handshake. The beat stays held until every targeted
// channel has taken it. Beats whose select is out of range are consumed, dropped and counted.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             producer handshake
//   in_data, in_sel, in_bcast     payload, destination index, broadcast flag
//   out_valid/out_ready [N_OUT]   per-channel handshake
//   out_data [N_OUT*DATA_W]       every slice carries the held payload
//   err_drop                      one-cycle pulse after a dropped beat
//   drop_cnt                      saturating count of dropped beats
module stream_demux_n
  import stream_demux_n_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    err_drop,
  output logic [CNT_W-1:0]        drop_cnt
);

  // One extra bit so codes equal to N_OUT still compare correctly when SEL_W == clog2(N_OUT).
  localparam logic [SEL_W:0]   N_OUT_S = N_OUT[SEL_W:0];
  localparam logic [N_OUT-1:0] ONE_N   = {{(N_OUT-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [N_OUT-1:0]      pend_q, pend_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  busy, done, accept, sel_ok;
  logic [N_OUT-1:0]      fire;

  assign busy      = (state_q == ST_BUSY);
  assign out_valid = {N_OUT{busy}} & pend_q;
  assign fire      = out_valid & out_ready;
  assign done      = busy & ((pend_q & ~fire) == '0);
  // Combinational from out_ready so a retiring beat can be replaced without a bubble.
  assign in_ready  = !busy | done;
  assign accept    = in_valid & in_ready;
  assign sel_ok    = ({1'b0, in_sel} < N_OUT_S);

  assign err_drop  = err_q;
  assign drop_cnt  = cnt_q;

  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    assign out_data[i*DATA_W +: DATA_W] = data_q;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pend_d  = pend_q & ~fire;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (busy && pend_d == '0) state_d = ST_EMPTY;

    if (accept) begin
      if (in_bcast) begin
        data_d  = in_data;
        pend_d  = '1;
        state_d = ST_BUSY;
      end else if (sel_ok) begin
        data_d  = in_data;
        pend_d  = ONE_N << in_sel;
        state_d = ST_BUSY;
      end else begin
        // Dropped beat: the held beat (if done) still retires via the defaults above.
        err_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;

  localparam int DATA_W = 8;
  localparam int N_OUT  = 4;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic                    err_drop;
  logic [CNT_W-1:0]        drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  stream_demux_n #(.DATA_W(DATA_W), .N_OUT(N_OUT), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_drop(err_drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] slice(input int ch);
    return out_data[ch*DATA_W +: DATA_W];
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0;
    out_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'h0);
    chk("rst_err_drop",  32'(err_drop),  32'h0);
    tick();
    chk("idle_in_ready", 32'(in_ready),  32'h1);

    // Unicast
    out_ready = 4'b1111;
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 3'd2;
    #1 chk("uni_in_ready_pre", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0; #1;
    chk("uni_out_valid", 32'(out_valid), 32'h4);
    chk("uni_slice2",    32'(slice(2)),  32'hA5);
    chk("uni_in_ready",  32'(in_ready),  32'h1);
    tick();
    chk("uni_retired",   32'(out_valid), 32'h0);

    // Backpressure on channel 1
    out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 8'h5A; in_sel = 3'd1;
    tick();
    in_valid = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_out_valid", 32'(out_valid), 32'h2);
      chk("bp_slice1",    32'(slice(1)),  32'h5A);
      chk("bp_in_ready",  32'(in_ready),  32'h0);
      tick();
    end
    out_ready = 4'b1111; #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bp_retired", 32'(out_valid), 32'h0);

    // Broadcast with staggered readies
    out_ready = 4'b0000;
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h3C; in_sel = 3'd6;
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; #1;
    chk("bc_valid0",    32'(out_valid), 32'hF);
    chk("bc_in_ready0", 32'(in_ready),  32'h0);
    out_ready = 4'b0001; #1;
    chk("bc_in_ready1", 32'(in_ready),  32'h0);
    tick();
    chk("bc_valid1",    32'(out_valid), 32'hE);
    chk("bc_slice3",    32'(slice(3)),  32'h3C);
    out_ready = 4'b0100; #1;
    chk("bc_in_ready2", 32'(in_ready),  32'h0);
    tick();
    chk("bc_valid2",    32'(out_valid), 32'hA);
    chk("bc_slice1",    32'(slice(1)),  32'h3C);
    out_ready = 4'b1010; #1;
    chk("bc_in_ready3", 32'(in_ready),  32'h1);
    tick();
    chk("bc_valid3",    32'(out_valid), 32'h0);

    // Out-of-range select
    out_ready = 4'b1111;
    in_valid = 1'b1; in_sel = 3'd5; in_data = 8'h77;
    tick();
    in_valid = 1'b0; #1;
    chk("oor_out_valid", 32'(out_valid), 32'h0);
    chk("oor_err_drop",  32'(err_drop),  32'h1);
    chk("oor_drop_cnt",  32'(drop_cnt),  32'h1);
    tick();
    chk("oor_err_clear", 32'(err_drop),  32'h0);

    // 299 more drops -> 300 total, counter saturates
    in_valid = 1'b1;
    repeat (299) tick();
    chk("sat_err_drop", 32'(err_drop), 32'h1);
    in_valid = 1'b0;
    tick();
    chk("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
    chk("sat_err_clear", 32'(err_drop), 32'h0);

    // Back-to-back unicast, no gaps
    in_valid = 1'b1; in_data = 8'h11; in_sel = 3'd0;
    tick();
    chk("b2b_v0", 32'(out_valid), 32'h1);
    chk("b2b_d0", 32'(slice(0)),  32'h11);
    in_data = 8'h22; in_sel = 3'd3; #1;
    chk("b2b_rdy1", 32'(in_ready), 32'h1);
    tick();
    chk("b2b_v1", 32'(out_valid), 32'h8);
    chk("b2b_d1", 32'(slice(3)),  32'h22);
    in_data = 8'h33; in_sel = 3'd0;
    tick();
    chk("b2b_v2", 32'(out_valid), 32'h1);
    chk("b2b_d2", 32'(slice(0)),  32'h33);
    // Drop while the held beat retires: held beat must still leave
    in_sel = 3'd7; in_data = 8'h99;
    tick();
    in_valid = 1'b0; #1;
    chk("dropdone_valid", 32'(out_valid), 32'h0);
    chk("dropdone_err",   32'(err_drop),  32'h1);
    chk("dropdone_sat",   32'(drop_cnt),  32'hFF);

    // Reset asserted mid-BUSY clears outputs immediately
    out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 8'hC3; in_sel = 3'd1;
    tick();
    in_valid = 1'b0; #1;
    chk("mid_busy_valid", 32'(out_valid), 32'h2);
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_cnt",   32'(drop_cnt),  32'h0);
    chk("mid_rst_rdy",   32'(in_ready),  32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
